// File: rtl/id_stage_hz.sv
// Decode stage: decodes OP / OP-IMM / LOAD, reads operands with EX/WB bypass,
// stalls on unresolved EX hazards and holds one registered ID/EX slot.
module id_stage_hz #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int FWD_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [4:0]      out_rd_o,
    output logic            out_rd_we_o,
    output logic            out_is_load_o,
    output logic            out_illegal_o,
    output logic [XLEN-1:0] out_op_a_o,
    output logic [XLEN-1:0] out_op_b_o,
    output logic [3:0]      out_alu_op_o,
    input  logic            ex_rd_we_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            ex_data_valid_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i
);

    localparam int         AW        = $clog2(NREG);
    localparam bit         FWD       = (FWD_EN != 0);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign rd     = instr_i[11:7];
    assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};

    logic [XLEN-1:0] rf [NREG];

    logic [1:0][4:0]      src;
    logic [1:0][XLEN-1:0] src_val;
    logic [1:0]           src_hz;
    logic [1:0]           src_oor;

    assign src[0] = instr_i[19:15];
    assign src[1] = instr_i[24:20];

    // Per-source operand select (x0, EX bypass, WB bypass, register file) and hazard.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic ex_match;
            assign ex_match     = ex_rd_we_i && (ex_rd_i == src[gi]) && (src[gi] != 5'd0);
            assign src_oor[gi]  = (int'(src[gi]) >= NREG);
            assign src_hz[gi]   = ex_match && (!ex_data_valid_i || !FWD);
            assign src_val[gi]  = (src[gi] == 5'd0)                   ? '0 :
                                  (FWD && ex_match && ex_data_valid_i) ? ex_data_i :
                                  (wb_we_i && (wb_rd_i == src[gi]))   ? wb_data_i :
                                  rf[src[gi][AW-1:0]];
        end
    endgenerate

    logic            dec_known;
    logic            dec_uses_rs2;
    logic            dec_alt;
    logic            dec_is_load;
    logic            dec_illegal;
    logic            dec_rd_we;
    logic [XLEN-1:0] dec_op_a;
    logic [XLEN-1:0] dec_op_b;
    logic [3:0]      dec_alu_op;
    logic            hazard;
    logic            accept;

    always_comb begin
        dec_known    = 1'b0;
        dec_uses_rs2 = 1'b0;
        dec_alt      = 1'b0;
        dec_is_load  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_known    = 1'b1;
                dec_uses_rs2 = 1'b1;
                dec_alt      = instr_i[30];
            end
            OPC_IMM: begin
                dec_known = 1'b1;
                dec_alt   = (funct3 == 3'b101) && instr_i[30];
            end
            OPC_LOAD: begin
                dec_known   = 1'b1;
                dec_is_load = 1'b1;
            end
            default: ;
        endcase

        // Only fields that are real register indices count toward the range check.
        dec_illegal = !dec_known || src_oor[0] || (dec_uses_rs2 && src_oor[1])
                      || (int'(rd) >= NREG);
        dec_rd_we   = !dec_illegal && (rd != 5'd0);
        dec_op_a    = dec_illegal ? '0 : src_val[0];
        dec_op_b    = dec_illegal ? '0 : (dec_uses_rs2 ? src_val[1] : imm_i);
        dec_alu_op  = (dec_illegal || dec_is_load) ? 4'b0000 : {dec_alt, funct3};
        hazard      = !dec_illegal && (src_hz[0] || (dec_uses_rs2 && src_hz[1]));
    end

    logic            valid_reg;
    logic [XLEN-1:0] pc_reg;
    logic [4:0]      rd_reg;
    logic            rd_we_reg;
    logic            is_load_reg;
    logic            illegal_reg;
    logic [XLEN-1:0] op_a_reg;
    logic [XLEN-1:0] op_b_reg;
    logic [3:0]      alu_op_reg;

    assign in_ready_o = flush_i || ((!valid_reg || out_ready_i) && !hazard);
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_we_i) begin
            for (int i = 1; i < NREG; i++) begin
                if (int'(wb_rd_i) == i) rf[i] <= wb_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_reg   <= 1'b0;
            pc_reg      <= '0;
            rd_reg      <= '0;
            rd_we_reg   <= 1'b0;
            is_load_reg <= 1'b0;
            illegal_reg <= 1'b0;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            alu_op_reg  <= '0;
        end else if (flush_i) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg   <= 1'b1;
            pc_reg      <= pc_i;
            rd_reg      <= rd;
            rd_we_reg   <= dec_rd_we;
            is_load_reg <= dec_is_load && !dec_illegal;
            illegal_reg <= dec_illegal;
            op_a_reg    <= dec_op_a;
            op_b_reg    <= dec_op_b;
            alu_op_reg  <= dec_alu_op;
        end else if (out_ready_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid_o   = valid_reg;
    assign out_pc_o      = pc_reg;
    assign out_rd_o      = rd_reg;
    assign out_rd_we_o   = rd_we_reg;
    assign out_is_load_o = is_load_reg;
    assign out_illegal_o = illegal_reg;
    assign out_op_a_o    = op_a_reg;
    assign out_op_b_o    = op_b_reg;
    assign out_alu_op_o  = alu_op_reg;

endmodule
